link_align_monitor: RTL and testbench

LINK_ALIGN_MONITOR -- requirements
Module: link_align_monitor

---
 rtl/link_align_pkg.sv | 27 ++
 rtl/link_align_monitor_if.sv | 35 +++
 rtl/sat_counter.sv | 28 ++
 rtl/link_align_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_link_align_monitor.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_align_pkg.sv
// link_align_pkg
// Shared definitions for the link alignment monitor: the FSM state type,
// whose values double as the externally visible status encoding, and the
// default comma character (K28.5).
package link_align_pkg;

  localparam logic [2:0] STATUS_IDLE   = 3'd0;
  localparam logic [2:0] STATUS_HUNT   = 3'd1;
  localparam logic [2:0] STATUS_SLIDE  = 3'd2;
  localparam logic [2:0] STATUS_WAIT   = 3'd3;
  localparam logic [2:0] STATUS_VERIFY = 3'd4;
  localparam logic [2:0] STATUS_LOCKED = 3'd5;
  localparam logic [2:0] STATUS_FAIL   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = STATUS_IDLE,
    ST_HUNT   = STATUS_HUNT,
    ST_SLIDE  = STATUS_SLIDE,
    ST_WAIT   = STATUS_WAIT,
    ST_VERIFY = STATUS_VERIFY,
    ST_LOCKED = STATUS_LOCKED,
    ST_FAIL   = STATUS_FAIL
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/link_align_monitor_if.sv
// link_align_monitor_if
// Bundles the GTX-side receive signals and the monitor status outputs.
//   rx_reset_done, resync, rxdata, rxk : toward the monitor
//   rxslide, link_ready, link_fail, frame_start, status,
//   slide_count, err_count, loss_count  : from the monitor
// master: the side driving receive data (transceiver wrapper / bench)
// slave : the monitor itself
interface link_align_monitor_if #(
  parameter int unsigned DATA_W = 16
);
  logic                  rx_reset_done;
  logic                  resync;
  logic [DATA_W-1:0]     rxdata;
  logic [DATA_W/8-1:0]   rxk;
  logic                  rxslide;
  logic                  link_ready;
  logic                  link_fail;
  logic                  frame_start;
  logic [2:0]            status;
  logic [7:0]            slide_count;
  logic [15:0]           err_count;
  logic [15:0]           loss_count;

  modport master (
    output rx_reset_done, resync, rxdata, rxk,
    input  rxslide, link_ready, link_fail, frame_start, status,
           slide_count, err_count, loss_count
  );

  modport slave (
    input  rx_reset_done, resync, rxdata, rxk,
    output rxslide, link_ready, link_fail, frame_start, status,
           slide_count, err_count, loss_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   i_clr   : synchronous clear
//   i_inc   : increment by one when not saturated
//   o_count : current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/link_align_monitor.sv
// link_align_monitor
// Hunts for a comma on lane 0 of the RX word stream, issues rxslide pulses
// to the transceiver until the comma lands at a stable frame position,
// verifies LOCK_CNT consecutive commas, then supervises the lock and falls
// back to hunting after LOSS_THRESH consecutive missed commas.
//   rxusrclk2 : clock
//   reset     : synchronous active-high reset
//   bus       : receive inputs and monitor outputs (slave modport)
//
// state  | meaning
// IDLE   | transceiver RX still in reset
// HUNT   | looking for a comma, FRAME_LEN words before giving up
// SLIDE  | issue one rxslide, or give up after MAX_SLIDES
// WAIT   | let the transceiver settle after a slide
// VERIFY | counting consecutive commas at frame boundaries
// LOCKED | aligned; counting misses at frame boundaries
// FAIL   | slide budget exhausted; waits for resync/reset
module link_align_monitor
  import link_align_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter logic [7:0]  COMMA       = K28_5,
  parameter int unsigned FRAME_LEN   = 1,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SLIDE_WAIT  = 24,
  parameter int unsigned MAX_SLIDES  = 16,
  parameter int unsigned LOSS_THRESH = 3
) (
  input logic                rxusrclk2,
  input logic                reset,
  link_align_monitor_if.slave bus
);
  localparam int unsigned POS_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);
  localparam int unsigned WAIT_W = (SLIDE_WAIT > 1) ? $clog2(SLIDE_WAIT) : 1;

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_THRESH);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIDE_WAIT - 1);
  localparam logic [7:0]        SLIDE_MAX = 8'(MAX_SLIDES);

  state_t              r_state, w_state_nxt;
  logic [POS_W-1:0]    r_pos, w_pos_nxt;
  logic [GOOD_W-1:0]   r_good, w_good_nxt;
  logic [MISS_W-1:0]   r_miss, w_miss_nxt;
  logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
  logic [7:0]          r_slide_count, w_slide_nxt;
  logic                r_rxslide, w_rxslide_nxt;
  logic                r_frame_start, w_fs_nxt;
  logic                r_link_ready, r_link_fail;
  logic                w_err_inc, w_loss_inc;
  logic [15:0]         w_err_count, w_loss_count;

  logic w_comma;
  logic w_pos_wrap;
  logic [POS_W-1:0] w_pos_inc;
  logic w_unused_lanes;

  assign w_comma    = (bus.rxdata[7:0] == COMMA) && bus.rxk[0];
  assign w_unused_lanes = ^{bus.rxdata[DATA_W-1:8], bus.rxk[DATA_W/8-1:1]};

  // r_pos holds the position of the last sampled word, so the word being
  // sampled now sits on a frame boundary exactly when r_pos is the last slot.
  assign w_pos_wrap = (r_pos == POS_LAST);
  assign w_pos_inc  = w_pos_wrap ? '0 : r_pos + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_good_nxt    = r_good;
    w_miss_nxt    = r_miss;
    w_wait_nxt    = r_wait;
    w_slide_nxt   = r_slide_count;
    w_rxslide_nxt = 1'b0;
    w_fs_nxt      = 1'b0;
    w_err_inc     = 1'b0;
    w_loss_inc    = 1'b0;

    if (!bus.rx_reset_done) begin
      w_state_nxt = ST_IDLE;
      w_pos_nxt   = '0;
      w_good_nxt  = '0;
      w_miss_nxt  = '0;
      w_wait_nxt  = '0;
      w_slide_nxt = '0;
    end else if (bus.resync && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_HUNT;
      w_pos_nxt   = '0;
      w_good_nxt  = '0;
      w_miss_nxt  = '0;
      w_wait_nxt  = '0;
      w_slide_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_HUNT;
          w_pos_nxt   = '0;
        end
        ST_HUNT: begin
          // In HUNT r_pos counts comma-less words seen so far.
          if (w_comma) begin
            w_state_nxt = ST_VERIFY;
            w_pos_nxt   = '0;
            w_good_nxt  = GOOD_W'(1);
          end else if (w_pos_wrap) begin
            w_state_nxt = ST_SLIDE;
          end else begin
            w_pos_nxt = w_pos_inc;
          end
        end
        ST_SLIDE: begin
          if (r_slide_count == SLIDE_MAX) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt   = ST_WAIT;
            w_rxslide_nxt = 1'b1;
            w_slide_nxt   = r_slide_count + 8'd1;
            w_wait_nxt    = WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_wait == '0) begin
            w_state_nxt = ST_HUNT;
            w_pos_nxt   = '0;
          end else begin
            w_wait_nxt = r_wait - 1'b1;
          end
        end
        ST_VERIFY: begin
          w_pos_nxt = w_pos_inc;
          if (w_pos_wrap) begin
            if (!w_comma) begin
              w_state_nxt = ST_SLIDE;
            end else if (r_good + 1'b1 == GOOD_LOCK) begin
              w_state_nxt = ST_LOCKED;
              w_miss_nxt  = '0;
            end else begin
              w_good_nxt = r_good + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          w_pos_nxt = w_pos_inc;
          if (w_pos_wrap) begin
            if (w_comma) begin
              w_miss_nxt = '0;
              w_fs_nxt   = 1'b1;
            end else begin
              w_err_inc = 1'b1;
              if (r_miss + 1'b1 == MISS_LOSS) begin
                w_state_nxt = ST_HUNT;
                w_pos_nxt   = '0;
                w_good_nxt  = '0;
                w_miss_nxt  = '0;
                w_slide_nxt = '0;
                w_loss_inc  = 1'b1;
              end else begin
                w_miss_nxt = r_miss + 1'b1;
              end
            end
          end
        end
        ST_FAIL: w_state_nxt = ST_FAIL;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rxusrclk2) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pos         <= '0;
      r_good        <= '0;
      r_miss        <= '0;
      r_wait        <= '0;
      r_slide_count <= '0;
      r_rxslide     <= 1'b0;
      r_frame_start <= 1'b0;
      r_link_ready  <= 1'b0;
      r_link_fail   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pos         <= w_pos_nxt;
      r_good        <= w_good_nxt;
      r_miss        <= w_miss_nxt;
      r_wait        <= w_wait_nxt;
      r_slide_count <= w_slide_nxt;
      r_rxslide     <= w_rxslide_nxt;
      r_frame_start <= w_fs_nxt;
      r_link_ready  <= (w_state_nxt == ST_LOCKED);
      r_link_fail   <= (w_state_nxt == ST_FAIL);
    end
  end

  sat_counter #(.WIDTH(16)) u_err_cnt (
    .i_clk   (rxusrclk2),
    .i_reset (reset),
    .i_clr   (1'b0),
    .i_inc   (w_err_inc),
    .o_count (w_err_count)
  );

  sat_counter #(.WIDTH(16)) u_loss_cnt (
    .i_clk   (rxusrclk2),
    .i_reset (reset),
    .i_clr   (1'b0),
    .i_inc   (w_loss_inc),
    .o_count (w_loss_count)
  );

  assign bus.rxslide     = r_rxslide;
  assign bus.link_ready  = r_link_ready;
  assign bus.link_fail   = r_link_fail;
  assign bus.frame_start = r_frame_start;
  assign bus.status      = r_state;
  assign bus.slide_count = r_slide_count;
  assign bus.err_count   = w_err_count;
  assign bus.loss_count  = w_loss_count;
endmodule

// File: tb/tb_link_align_monitor.sv
// tb_link_align_monitor
// Three monitor instances: default parameters (u16), FRAME_LEN=8 (u8) and
// DATA_W=32 (u32). Expected values are queued when a cycle's stimulus is
// driven and compared just after the following rising edge.
module tb_link_align_monitor;
  import link_align_pkg::*;

  localparam int F_ST = 0, F_RDY = 1, F_FAIL = 2, F_FS = 3;
  localparam int F_SL = 4, F_SC = 5, F_ERR = 6, F_LOSS = 7;

  logic clk;
  logic rst16, rst8, rst32;

  link_align_monitor_if #(.DATA_W(16)) if16 ();
  link_align_monitor_if #(.DATA_W(16)) if8 ();
  link_align_monitor_if #(.DATA_W(32)) if32 ();

  link_align_monitor #(.DATA_W(16)) u16 (
    .rxusrclk2 (clk), .reset (rst16), .bus (if16));
  link_align_monitor #(.DATA_W(16), .FRAME_LEN(8)) u8 (
    .rxusrclk2 (clk), .reset (rst8), .bus (if8));
  link_align_monitor #(.DATA_W(32)) u32 (
    .rxusrclk2 (clk), .reset (rst32), .bus (if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          unit;
    int          field;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        rrd;
    logic        rsy;
    logic [15:0] data;
    logic [1:0]  k;
    logic [2:0]  st;
    logic        rdy;
    logic        fs;
    logic        sl;
    logic [15:0] err;
    logic [15:0] loss;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic string fname(input int f);
    case (f)
      F_ST:    return "status";
      F_RDY:   return "link_ready";
      F_FAIL:  return "link_fail";
      F_FS:    return "frame_start";
      F_SL:    return "rxslide";
      F_SC:    return "slide_count";
      F_ERR:   return "err_count";
      default: return "loss_count";
    endcase
  endfunction

  function automatic logic [31:0] pick(input int f, input logic [2:0] st,
      input logic rdy, input logic fl, input logic fs, input logic sl,
      input logic [7:0] sc, input logic [15:0] err, input logic [15:0] loss);
    case (f)
      F_ST:    return {29'd0, st};
      F_RDY:   return {31'd0, rdy};
      F_FAIL:  return {31'd0, fl};
      F_FS:    return {31'd0, fs};
      F_SL:    return {31'd0, sl};
      F_SC:    return {24'd0, sc};
      F_ERR:   return {16'd0, err};
      default: return {16'd0, loss};
    endcase
  endfunction

  function automatic logic [31:0] get_field(input int u, input int f);
    case (u)
      0: return pick(f, if16.status, if16.link_ready, if16.link_fail, if16.frame_start,
                     if16.rxslide, if16.slide_count, if16.err_count, if16.loss_count);
      1: return pick(f, if8.status, if8.link_ready, if8.link_fail, if8.frame_start,
                     if8.rxslide, if8.slide_count, if8.err_count, if8.loss_count);
      default: return pick(f, if32.status, if32.link_ready, if32.link_fail, if32.frame_start,
                     if32.rxslide, if32.slide_count, if32.err_count, if32.loss_count);
    endcase
  endfunction

  task automatic push(input int u, input int f, input logic [31:0] v, input string nm);
    sb_t it;
    it.name = nm; it.unit = u; it.field = f; it.exp = v;
    sb.push_back(it);
  endtask

  task automatic tick();
    sb_t it;
    logic [31:0] act;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      act = get_field(it.unit, it.field);
      n_checks++;
      if (act !== it.exp) begin
        n_errors++;
        $display("FAIL %s u%0d %s got %0h want %0h at %0t",
                 it.name, it.unit, fname(it.field), act, it.exp, $time);
      end
    end
  endtask

  task automatic do_reset(input int u);
    case (u)
      0: begin rst16 = 1'b1; if16.rx_reset_done = 1'b0; if16.resync = 1'b0;
               if16.rxdata = '0; if16.rxk = '0; end
      1: begin rst8 = 1'b1; if8.rx_reset_done = 1'b0; if8.resync = 1'b0;
               if8.rxdata = '0; if8.rxk = '0; end
      default: begin rst32 = 1'b1; if32.rx_reset_done = 1'b0; if32.resync = 1'b0;
               if32.rxdata = '0; if32.rxk = '0; end
    endcase
    tick();
    for (int f = 0; f < 8; f++) push(u, f, 32'd0, "reset_state");
    tick();
    case (u)
      0: rst16 = 1'b0;
      1: rst8 = 1'b0;
      default: rst32 = 1'b0;
    endcase
  endtask

  function automatic vec_t mk(input logic rrd, input logic rsy, input logic [15:0] d,
      input logic [1:0] k, input logic [2:0] st, input logic rdy, input logic fs,
      input logic sl, input logic [15:0] err, input logic [15:0] loss);
    vec_t v;
    v.rrd = rrd; v.rsy = rsy; v.data = d; v.k = k; v.st = st;
    v.rdy = rdy; v.fs = fs; v.sl = sl; v.err = err; v.loss = loss;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst16 = 1'b1; rst8 = 1'b1; rst32 = 1'b1;
    if16.rx_reset_done = 1'b0; if16.resync = 1'b0; if16.rxdata = '0; if16.rxk = '0;
    if8.rx_reset_done  = 1'b0; if8.resync  = 1'b0; if8.rxdata  = '0; if8.rxk  = '0;
    if32.rx_reset_done = 1'b0; if32.resync = 1'b0; if32.rxdata = '0; if32.rxk = '0;

    // Lock, tolerated misses, loss of lock, resync, verify miss, slide, IDLE.
    //               rrd rsy data      k      st rdy fs sl err loss
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 5, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b00, 5, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'hBC00, 2'b10, 5, 1, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 16'h55BC, 2'b11, 5, 1, 1, 0, 2, 0));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 5, 1, 1, 0, 2, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 2'b00, 5, 1, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 16'h00BD, 2'b01, 5, 1, 0, 0, 4, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 2'b00, 1, 0, 0, 0, 5, 1));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 4, 0, 0, 0, 5, 1));
    tbl.push_back(mk(1, 1, 16'h00BC, 2'b01, 1, 0, 0, 0, 5, 1));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 4, 0, 0, 0, 5, 1));
    tbl.push_back(mk(1, 0, 16'hBC00, 2'b10, 2, 0, 0, 0, 5, 1));
    tbl.push_back(mk(1, 0, 16'h00BC, 2'b01, 3, 0, 0, 1, 5, 1));
    tbl.push_back(mk(0, 0, 16'h00BC, 2'b01, 0, 0, 0, 0, 5, 1));

    do_reset(0);
    for (int i = 0; i < tbl.size(); i++) begin
      if16.rx_reset_done = tbl[i].rrd;
      if16.resync        = tbl[i].rsy;
      if16.rxdata        = tbl[i].data;
      if16.rxk           = tbl[i].k;
      push(0, F_ST,   {29'd0, tbl[i].st},  $sformatf("vec%0d", i));
      push(0, F_RDY,  {31'd0, tbl[i].rdy}, $sformatf("vec%0d", i));
      push(0, F_FS,   {31'd0, tbl[i].fs},  $sformatf("vec%0d", i));
      push(0, F_SL,   {31'd0, tbl[i].sl},  $sformatf("vec%0d", i));
      push(0, F_ERR,  {16'd0, tbl[i].err}, $sformatf("vec%0d", i));
      push(0, F_LOSS, {16'd0, tbl[i].loss}, $sformatf("vec%0d", i));
      tick();
    end

    // No commas: 16 slides spaced 26 cycles, then FAIL, then resync.
    do_reset(0);
    if16.rx_reset_done = 1'b1;
    for (int n = 0; n <= 418; n++) begin
      v = (n >= 2 && ((n - 2) % 26) == 0 && ((n - 2) / 26) < 16) ? 32'd1 : 32'd0;
      push(0, F_SL, v, "slide_pulse");
      if (n == 417) push(0, F_ST, 32'd2, "last_slide_state");
      if (n == 418) begin
        push(0, F_ST, 32'd6, "fail_state");
        push(0, F_FAIL, 32'd1, "link_fail");
        push(0, F_SC, 32'd16, "slide_sat");
      end
      tick();
    end
    if16.resync = 1'b1;
    push(0, F_ST, 32'd1, "resync_hunt");
    push(0, F_SC, 32'd0, "resync_sc");
    push(0, F_FAIL, 32'd0, "resync_fail");
    tick();
    if16.resync = 1'b0;

    // Reset while WAIT, with rxslide high.
    do_reset(0);
    if16.rx_reset_done = 1'b1;
    tick();
    push(0, F_ST, 32'd2, "to_slide");
    tick();
    push(0, F_ST, 32'd3, "to_wait");
    push(0, F_SL, 32'd1, "slide_hi");
    push(0, F_SC, 32'd1, "sc_one");
    tick();
    rst16 = 1'b1;
    for (int f = 0; f < 8; f++) push(0, f, 32'd0, "rst_in_wait");
    tick();
    rst16 = 1'b0;

    // rx_reset_done dropped while LOCKED.
    do_reset(0);
    if16.rx_reset_done = 1'b1;
    if16.rxdata = 16'h00BC; if16.rxk = 2'b01;
    for (int n = 0; n <= 5; n++) begin
      push(0, F_RDY, (n >= 4) ? 32'd1 : 32'd0, "relock");
      tick();
    end
    if16.rx_reset_done = 1'b0;
    for (int f = 0; f < 8; f++) push(0, f, 32'd0, "rrd_drop");
    tick();

    // FRAME_LEN=8: lock on boundary commas, displaced comma counts an error.
    do_reset(1);
    if8.rx_reset_done = 1'b1;
    for (int w = 0; w <= 70; w++) begin
      if ((((w % 8) == 0) && (w != 56)) || (w == 57)) begin
        if8.rxdata = 16'h00BC; if8.rxk = 2'b01;
      end else begin
        if8.rxdata = 16'h0000; if8.rxk = 2'b00;
      end
      push(1, F_RDY, (w >= 32) ? 32'd1 : 32'd0, "f8_ready");
      push(1, F_FS, (w >= 40 && (w % 8) == 0 && w != 56) ? 32'd1 : 32'd0, "f8_fs");
      push(1, F_ERR, (w >= 56) ? 32'd1 : 32'd0, "f8_err");
      if (w == 7) push(1, F_ST, 32'd1, "f8_hunt");
      if (w == 8) push(1, F_ST, 32'd4, "f8_verify");
      tick();
    end

    // DATA_W=32: lane-1 comma never locks; lane-0 comma locks.
    do_reset(2);
    if32.rx_reset_done = 1'b1;
    for (int w = 0; w <= 90; w++) begin
      if (w < 60) begin
        if32.rxdata = 32'h0000_BC00; if32.rxk = 4'b0010;
      end else begin
        if32.rxdata = 32'h0000_00BC; if32.rxk = 4'b0001;
      end
      v = (w < 60 && w >= 2 && ((w - 2) % 26) == 0) ? 32'd1 : 32'd0;
      push(2, F_SL, v, "w32_slide");
      push(2, F_RDY, (w >= 82) ? 32'd1 : 32'd0, "w32_ready");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
